hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch/jump redirect flushing,
// and data-memory wait stalls with a timeout that sets a sticky error.
//   state    | meaning
//   RUN      | normal issue; evaluates mem wait > redirect > load-use
//   MEM_WAIT | front end and mem stalled until ack or timeout
//   REDIRECT | one cycle squashing the wrong-path fetch
module hazard_ctrl #(
    parameter int AWIDTH      = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        id_opcode_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic [4:0]        ex_rd_i,
    input  logic              ex_is_load_i,
    input  logic              ex_redirect_i,
    input  logic [AWIDTH-1:0] ex_target_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ack_i,
    output logic              if_stall_o,
    output logic              id_stall_o,
    output logic              ex_flush_o,
    output logic              id_flush_o,
    output logic              mem_stall_o,
    output logic              pc_sel_o,
    output logic [AWIDTH-1:0] pc_target_o,
    output logic [1:0]        state_o,
    output logic              err_o,
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       flush_cnt_o
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1) + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            err_q, err_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;
    logic [15:0]     flush_cnt_q, flush_cnt_d;

    logic            rs1_used, rs2_used, load_use, mem_wait;
    logic            if_stall, id_stall, ex_flush, id_flush, mem_stall, pc_sel;

    always_comb begin
        rs1_used = !(id_opcode_i == OPC_LUI || id_opcode_i == OPC_AUIPC ||
                     id_opcode_i == OPC_JAL);
        rs2_used = (id_opcode_i == OPC_BRANCH || id_opcode_i == OPC_STORE ||
                    id_opcode_i == OPC_OP);
        load_use = ex_is_load_i && (ex_rd_i != 5'd0) &&
                   ((rs1_used && ex_rd_i == id_rs1_i) ||
                    (rs2_used && ex_rd_i == id_rs2_i));
        mem_wait = dmem_req_i && !dmem_ack_i;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        if_stall   = 1'b0;
        id_stall   = 1'b0;
        ex_flush   = 1'b0;
        id_flush   = 1'b0;
        mem_stall  = 1'b0;
        pc_sel     = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    if_stall   = 1'b1;
                    id_stall   = 1'b1;
                    mem_stall  = 1'b1;
                    wait_cnt_d = CW'(MEM_TIMEOUT - 1);
                    state_d    = MEM_WAIT;
                end else if (ex_redirect_i) begin
                    pc_sel   = 1'b1;
                    id_flush = 1'b1;
                    ex_flush = 1'b1;
                    state_d  = REDIRECT;
                end else if (load_use) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    ex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack_i) begin
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end else if (wait_cnt_q == '0) begin
                    // Give up on the access: release the pipe and flag it.
                    err_d   = 1'b1;
                    state_d = RUN;
                end else begin
                    if_stall   = 1'b1;
                    id_stall   = 1'b1;
                    mem_stall  = 1'b1;
                    wait_cnt_d = wait_cnt_q - CW'(1);
                end
            end
            REDIRECT: begin
                id_flush = 1'b1;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase

        if (rst) begin
            if_stall  = 1'b0;
            id_stall  = 1'b0;
            ex_flush  = 1'b0;
            id_flush  = 1'b0;
            mem_stall = 1'b0;
            pc_sel    = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (id_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        flush_cnt_d = flush_cnt_q;
        if (id_flush && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign if_stall_o  = if_stall;
    assign id_stall_o  = id_stall;
    assign ex_flush_o  = ex_flush;
    assign id_flush_o  = id_flush;
    assign mem_stall_o = mem_stall;
    assign pc_sel_o    = pc_sel;
    assign pc_target_o = pc_sel ? ex_target_i : '0;
    assign state_o     = state_q;
    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
